// File: rtl/frame_sched_pkg.sv
// frame_sched_pkg: state encoding and width helper shared by the frame scheduler.
package frame_sched_pkg;

  typedef enum logic {IDLE, SEND} state_t;

  // Width of an index/counter over n items, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_rr_arbiter.sv
// frame_rr_arbiter: picks one active requester and returns it one-hot and encoded.
// FRAME_SCHED_RR_EN selects rotating priority from i_ptr; otherwise lowest index wins.
module frame_rr_arbiter
  import frame_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = min1_clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
`ifdef FRAME_SCHED_RR_EN
  input  logic [IDW-1:0]  i_ptr,
`endif
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_winner,
  output logic            o_any
);

  logic [IDW-1:0] idx;

  // Scan requesters in priority order and keep the first active one.
  always_comb begin
    o_gnt    = '0;
    o_winner = '0;
    o_any    = 1'b0;
    idx      = '0;
    if (i_en) begin
      for (int i = 0; i < NREQ; i++) begin
`ifdef FRAME_SCHED_RR_EN
        idx = IDW'((int'(i_ptr) + i) % NREQ);
`else
        idx = IDW'(i);
`endif
        if (!o_any && i_req[idx]) begin
          o_any    = 1'b1;
          o_winner = idx;
        end
      end
      if (o_any) begin
        o_gnt[o_winner] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/piso.sv
// piso: parallel-in/serial-out word shift register; word 0 is presented first,
// TAIL is shifted in behind the last word.
module piso #(
  parameter int BIT   = 8,
  parameter int NDATA = 3,
  parameter int TAIL  = 0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_load,
  input  logic                        i_shift,
  input  logic [0:NDATA-1][BIT-1:0]   i_data,
  output logic [BIT-1:0]              o_data
);

  logic [0:NDATA-1][BIT-1:0] sreg;

  // Load a whole frame, or advance one word toward the output slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sreg <= '0;
    end else if (i_load) begin
      sreg <= i_data;
    end else if (i_shift) begin
      for (int i = 0; i < NDATA - 1; i++) begin
        sreg[i] <= sreg[i+1];
      end
      sreg[NDATA-1] <= BIT'(TAIL);
    end
  end

  assign o_data = sreg[0];

endmodule

// File: rtl/frame_sched.sv
// frame_sched: grants one requester at a time, loads its frame into a shared PISO
// and streams the words over valid/ready with owner id and last flag.
// Define FRAME_SCHED_RR_EN for round-robin arbitration; default is fixed priority.
module frame_sched
  import frame_sched_pkg::*;
#(
  parameter  int BIT   = 8,
  parameter  int NDATA = 3,
  parameter  int NREQ  = 4,
  localparam int IDW   = min1_clog2(NREQ),
  localparam int CNTW  = min1_clog2(NDATA)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NREQ-1:0]                     i_req,
  input  logic [0:NREQ-1][0:NDATA-1][BIT-1:0] i_frame,
  output logic [NREQ-1:0]                     o_gnt,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [BIT-1:0]                      o_data,
  output logic [IDW-1:0]                      o_id,
  output logic                                o_last
);

  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NDATA - 1);

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [IDW-1:0]  winner;
  logic            any_req;
  logic            load;
  logic            shift;
  logic [BIT-1:0]  piso_data;
`ifdef FRAME_SCHED_RR_EN
  logic [IDW-1:0]  ptr;
`endif

  // Arbitration only runs while idle and out of reset, so a grant always means a load.
  frame_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req    (i_req),
`ifdef FRAME_SCHED_RR_EN
    .i_ptr    (ptr),
`endif
    .i_en     ((state == IDLE) && !i_rst),
    .o_gnt    (o_gnt),
    .o_winner (winner),
    .o_any    (any_req)
  );

  assign load  = any_req;
  assign shift = (state == SEND) && i_ready;

  piso #(
    .BIT   (BIT),
    .NDATA (NDATA),
    .TAIL  (0)
  ) u_piso (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (load),
    .i_shift (shift),
    .i_data  (i_frame[winner]),
    .o_data  (piso_data)
  );

  assign o_data = o_valid ? piso_data : '0;

  // Frame sequencing: grant in IDLE, count accepted beats in SEND, one idle bubble between frames.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_id    <= '0;
      o_last  <= 1'b0;
`ifdef FRAME_SCHED_RR_EN
      ptr     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= SEND;
            cnt     <= '0;
            o_id    <= winner;
            o_valid <= 1'b1;
            o_last  <= (NDATA == 1);
`ifdef FRAME_SCHED_RR_EN
            ptr     <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
`endif
          end
        end
        SEND: begin
          if (i_ready) begin
            if (cnt == LAST_CNT) begin
              state   <= IDLE;
              o_valid <= 1'b0;
              o_last  <= 1'b0;
            end else begin
              cnt    <= cnt + CNTW'(1);
              o_last <= ((cnt + CNTW'(1)) == LAST_CNT);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/frame_sched.md
# frame_sched

Round-robin scheduler that shares one parallel-in/serial-out shift register among several frame producers. Each requester offers a frame of NDATA words; the block grants one requester, loads its frame into the shared PISO, and streams the words out one per accepted beat over a valid/ready interface. Each beat carries the owner id and a last flag. The block sits between frame-building engines and a serial link or narrow bus.

## Interface
- BIT, 8, word width
- NDATA, 3, words per frame (≥1)
- NREQ, 4, number of requesters (≥1)

- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_req  in  NREQ  per-requester frame request; held until granted
- i_frame  in  [BIT-1:0] x [0:NREQ-1][0:NDATA-1]  frame words per requester; word 0 is sent first
- o_gnt  out  NREQ  one-hot grant pulse; the frame is sampled in this cycle
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts beat
- o_data  out  BIT  current word; 0 when o_valid=0
- o_id  out  $clog2(NREQ) (min 1)  index of the frame owner
- o_last  out  1  asserted with the final word of the frame

## Operation
- States: IDLE, SEND.
- IDLE: o_valid=0.
  - If any i_req bit is set, select a winner, assert o_gnt[winner] combinationally in the same cycle, and pulse PISO load with i_frame[winner].
  - Also latch o_id←winner, clear the beat counter, update the priority pointer, and go to SEND.
  - If no request is set, stay in IDLE with o_gnt=0.
- SEND: o_valid=1, o_data=PISO output.
  - On i_ready=1: pulse PISO shift and increment the counter.
  - If counter==NDATA-1 on that beat, go to IDLE.
  - On i_ready=0: hold; o_data, o_id and o_last stay stable.
- o_last = (state==SEND) && (counter==NDATA-1).
- Counter width is $clog2(NDATA), minimum 1. The counter never exceeds NDATA-1.
- Requests are ignored during SEND. A requester that drops i_req before it is granted is simply not granted. No grant is ever issued without a matching request.
- Reset mid-frame abandons the frame. The rest of that frame is never emitted, and the requester is not re-granted unless it requests again.

## Timing
- Reset values: state IDLE, o_gnt=0, o_valid=0, o_data=0, o_id=0, o_last=0, pointer=0, counter=0.
- Grant at cycle t. First beat is valid at t+1.
- With i_ready held high, the last beat is at t+NDATA and the next grant can occur at t+NDATA+1.
- Throughput: NDATA words per NDATA+1 cycles, because one IDLE bubble separates frames.
- NDATA=1: o_last is asserted with the first and only beat.
- o_gnt is combinational from i_req and state; it must not feed back into i_req combinationally.

## Configuration
- FRAME_SCHED_RR_EN defined: round-robin arbitration.
  - Search starts at the pointer and wraps at NREQ-1→0.
  - On grant, pointer←(winner+1) mod NREQ.
- Not defined: fixed priority. The lowest-index active requester wins and the pointer logic is removed.

## Structure
- Package frame_sched_pkg holds:
  - the state enum {IDLE, SEND};
  - a localparam function for the counter/id width (max($clog2(n),1)).
- Sub-module frame_rr_arbiter: given the request vector, pointer and an enable, produces the one-hot grant and the encoded winner. It contains the FRAME_SCHED_RR_EN switch.
- The datapath is the team's existing PISO module, instantiated with TAIL=0. i_load and i_shift are driven from the FSM.

## Test plan
- Single frame: NREQ=4, NDATA=3; i_req=0b0100 with frame {0x11,0x22,0x33}; i_ready=1.
  - o_gnt=0b0100 for 1 cycle.
  - Beats 0x11, 0x22, 0x33 with o_id=2; o_last only on 0x33; o_valid=0 the cycle after.
- Backpressure: same frame, with i_ready low for 2 cycles on beat 2.
  - 0x22 is held stable for 3 cycles with o_valid=1.
  - Total of exactly 3 accepted beats.
- Round-robin (RR_EN): all four i_req held high for 4 frames.
  - Grant order is 0,1,2,3.
  - Then request 3 alone and grant it; then requests 0 and 3 together → grant goes to 0.
- Fixed priority (no RR_EN): i_req=0b1010 held → requester 1 is granted every frame; requester 3 is never granted.
- Reset mid-frame: assert i_rst after beat 1 of 3.
  - Next cycle: o_valid=0, o_id=0, o_last=0.
  - No further beats until a new request arrives; a new grant then starts from word 0.
- NDATA=1: i_req=0b0001 with frame {0xA5}.
  - One beat 0xA5 with o_last=1.
  - The next grant is 2 cycles after the first.
